// File: rtl/decode_issue_ctrl.sv
// Fetch-to-decode issue controller: 2-entry fetch buffer, flush sequencing and a decoder-aligned valid.
// Define LOAD_USE_STALL_EN to enable load-use bubble insertion and the oBubbleCnt counter.
module decode_issue_ctrl #(
    parameter int cXLEN    = 32,
    parameter int cycleNum = 2
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iFetchValid,
    input  logic [cXLEN-1:0] iFetchInst,
    input  logic [cXLEN-1:0] iFetchPC,
    output logic             oFetchReady,
    input  logic             iExReady,
    input  logic             iFlushPipe,
    output logic [cXLEN-1:0] oInst,
    output logic [cXLEN-1:0] oCurPC,
    output logic             oFlushPipe,
    output logic             oDecValid,
    output logic [15:0]      oBubbleCnt
);
    localparam logic [cXLEN-1:0] cNop = cXLEN'(32'h0000_0013);
    localparam int cCntW = (cycleNum > 1) ? $clog2(cycleNum) : 1;
    localparam logic [cCntW-1:0] cFlushLoad = cCntW'(cycleNum - 1);

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    state_t              r_state;
    logic [cCntW-1:0]    r_flushCnt;
    logic [cXLEN-1:0]    r_instMem [2];
    logic [cXLEN-1:0]    r_pcMem [2];
    logic                r_wrPtr;
    logic                r_rdPtr;
    logic [1:0]          r_count;
    logic [cXLEN-1:0]    r_inst;
    logic [cXLEN-1:0]    r_curPC;
    logic                r_flushPipe;
    logic                r_issueValid;
    logic [cycleNum-1:0] r_validSr;

    logic             w_accept;
    logic             w_canIssue;
    logic             w_hazard;
    logic             w_stallStart;
    logic             w_issue;
    logic [cXLEN-1:0] w_headInst;
    logic [cXLEN-1:0] w_headPC;

    assign oFetchReady  = !iRst && (r_count < 2'd2) && (r_state != FLUSH);
    assign w_accept     = iFetchValid && oFetchReady && !iFlushPipe;
    assign w_headInst   = r_instMem[r_rdPtr];
    assign w_headPC     = r_pcMem[r_rdPtr];
    assign w_canIssue   = (r_count != 2'd0) && iExReady && !iFlushPipe && (r_state != FLUSH);
    // The STALL cycle itself issues the held head, so a hazard costs exactly one bubble.
    assign w_stallStart = w_canIssue && (r_state == RUN) && w_hazard;
    assign w_issue      = w_canIssue && !w_stallStart;

`ifdef LOAD_USE_STALL_EN
    logic        r_lastLoad;
    logic [4:0]  r_lastRd;
    logic [15:0] r_bubbleCnt;
    logic        w_usesRs2;

    assign w_usesRs2 = (w_headInst[6:0] == 7'b0110011) || (w_headInst[6:0] == 7'b0100011) ||
                       (w_headInst[6:0] == 7'b1100011);
    assign w_hazard  = r_lastLoad && ((w_headInst[19:15] == r_lastRd) ||
                       (w_usesRs2 && (w_headInst[24:20] == r_lastRd)));

    // A NOP counts as issued, so any bubble retires the load record.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_lastLoad  <= 1'b0;
            r_lastRd    <= 5'd0;
            r_bubbleCnt <= 16'd0;
        end else begin
            r_lastLoad <= w_issue && (w_headInst[6:0] == 7'b0000011) && (w_headInst[11:7] != 5'd0);
            r_lastRd   <= w_headInst[11:7];
            if (w_stallStart && (r_bubbleCnt != 16'hFFFF)) begin
                r_bubbleCnt <= r_bubbleCnt + 16'd1;
            end
        end
    end

    assign oBubbleCnt = r_bubbleCnt;
`else
    assign w_hazard   = 1'b0;
    assign oBubbleCnt = 16'd0;
`endif

    always_ff @(posedge iClk) begin
        if (w_accept) begin
            r_instMem[r_wrPtr] <= iFetchInst;
            r_pcMem[r_wrPtr]   <= iFetchPC;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state      <= RUN;
            r_flushCnt   <= '0;
            r_wrPtr      <= 1'b0;
            r_rdPtr      <= 1'b0;
            r_count      <= 2'd0;
            r_inst       <= cNop;
            r_curPC      <= '0;
            r_flushPipe  <= 1'b0;
            r_issueValid <= 1'b0;
            r_validSr    <= '0;
        end else if (iFlushPipe) begin
            r_state      <= FLUSH;
            r_flushCnt   <= cFlushLoad;
            r_wrPtr      <= 1'b0;
            r_rdPtr      <= 1'b0;
            r_count      <= 2'd0;
            r_inst       <= cNop;
            r_flushPipe  <= 1'b1;
            r_issueValid <= 1'b0;
            r_validSr    <= '0;
        end else begin
            r_flushPipe <= 1'b0;
            if (w_accept) begin
                r_wrPtr <= ~r_wrPtr;
            end
            if (w_issue) begin
                r_rdPtr <= ~r_rdPtr;
                r_curPC <= w_headPC;
            end
            case ({w_accept, w_issue})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            r_inst       <= w_issue ? w_headInst : cNop;
            r_issueValid <= w_issue;
            for (int i = cycleNum - 1; i > 0; i--) begin
                r_validSr[i] <= r_validSr[i-1];
            end
            r_validSr[0] <= r_issueValid;
            case (r_state)
                RUN: begin
                    if (w_stallStart) begin
                        r_state <= STALL;
                    end
                end
                STALL: r_state <= RUN;
                FLUSH: begin
                    if (r_flushCnt == '0) begin
                        r_state <= RUN;
                    end else begin
                        r_flushCnt <= r_flushCnt - cCntW'(1);
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign oInst      = r_inst;
    assign oCurPC     = r_curPC;
    assign oFlushPipe = r_flushPipe;
    assign oDecValid  = r_validSr[cycleNum-1];
endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Table-driven bench for decode_issue_ctrl; expectations follow LOAD_USE_STALL_EN when defined.
module tb_decode_issue_ctrl;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] IA   = 32'h0031_00B3;
    localparam logic [31:0] IB   = 32'h0041_8133;
    localparam logic [31:0] IC   = 32'h0052_01B3;
    localparam logic [31:0] ID   = 32'h0062_8233;
    localparam logic [31:0] LW5  = 32'h0000_A283;
    localparam logic [31:0] ADD5 = 32'h0022_8333;
    localparam logic [31:0] LW0  = 32'h0000_A003;
    localparam logic [31:0] ADD0 = 32'h0020_0333;
`ifdef LOAD_USE_STALL_EN
    localparam bit cStallEn = 1'b1;
`else
    localparam bit cStallEn = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        exr;
        logic        flush;
        logic        eRdy;
        logic [31:0] eInst;
        logic [31:0] ePC;
        logic        eFlush;
        logic        eDec;
        logic [15:0] eBub;
    } vec_t;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iFetchValid;
    logic [31:0] iFetchInst;
    logic [31:0] iFetchPC;
    logic        oFetchReady;
    logic        iExReady;
    logic        iFlushPipe;
    logic [31:0] oInst;
    logic [31:0] oCurPC;
    logic        oFlushPipe;
    logic        oDecValid;
    logic [15:0] oBubbleCnt;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    decode_issue_ctrl #(.cXLEN(32), .cycleNum(2)) dut (
        .iClk(iClk), .iRst(iRst), .iFetchValid(iFetchValid), .iFetchInst(iFetchInst),
        .iFetchPC(iFetchPC), .oFetchReady(oFetchReady), .iExReady(iExReady),
        .iFlushPipe(iFlushPipe), .oInst(oInst), .oCurPC(oCurPC), .oFlushPipe(oFlushPipe),
        .oDecValid(oDecValid), .oBubbleCnt(oBubbleCnt)
    );

    always #5 iClk = ~iClk;

    function automatic vec_t mkVec(logic rst, logic valid, logic [31:0] inst, logic [31:0] pc,
                                   logic exr, logic flush, logic eRdy, logic [31:0] eInst,
                                   logic [31:0] ePC, logic eFlush, logic eDec, logic [15:0] eBub);
        vec_t v;
        v.rst = rst; v.valid = valid; v.inst = inst; v.pc = pc; v.exr = exr; v.flush = flush;
        v.eRdy = eRdy; v.eInst = eInst; v.ePC = ePC; v.eFlush = eFlush; v.eDec = eDec; v.eBub = eBub;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        iRst        = v.rst;
        iFetchValid = v.valid;
        iFetchInst  = v.inst;
        iFetchPC    = v.pc;
        iExReady    = v.exr;
        iFlushPipe  = v.flush;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Ready is combinational and checked before the edge; everything else is checked after it.
    task automatic runVector(input vec_t v, input string tag);
        applyStimulus(v);
        #1;
        checkOutput({tag, ".ready"}, 32'(oFetchReady), 32'(v.eRdy));
        @(posedge iClk);
        #1;
        checkOutput({tag, ".inst"}, oInst, v.eInst);
        checkOutput({tag, ".pc"}, oCurPC, v.ePC);
        checkOutput({tag, ".flush"}, 32'(oFlushPipe), 32'(v.eFlush));
        checkOutput({tag, ".decValid"}, 32'(oDecValid), 32'(v.eDec));
        checkOutput({tag, ".bubbles"}, 32'(oBubbleCnt), 32'(v.eBub));
    endtask

    initial begin
        // reset, then four back-to-back ALU instructions
        tbl.push_back(mkVec(1, 0, 0,  0,      0, 0,  0, NOP, 32'h000, 0, 0, 0));
        tbl.push_back(mkVec(0, 1, IA, 32'h100, 1, 0, 1, NOP, 32'h000, 0, 0, 0));
        tbl.push_back(mkVec(0, 1, IB, 32'h104, 1, 0, 1, IA,  32'h100, 0, 0, 0));
        tbl.push_back(mkVec(0, 1, IC, 32'h108, 1, 0, 1, IB,  32'h104, 0, 0, 0));
        tbl.push_back(mkVec(0, 1, ID, 32'h10C, 1, 0, 1, IC,  32'h108, 0, 1, 0));
        tbl.push_back(mkVec(0, 0, 0,  0,      1, 0,  1, ID,  32'h10C, 0, 1, 0));
        tbl.push_back(mkVec(0, 0, 0,  0,      1, 0,  1, NOP, 32'h10C, 0, 1, 0));
        tbl.push_back(mkVec(0, 0, 0,  0,      1, 0,  1, NOP, 32'h10C, 0, 1, 0));
        tbl.push_back(mkVec(0, 0, 0,  0,      1, 0,  1, NOP, 32'h10C, 0, 0, 0));
        // fill with execute stalled, then drain
        tbl.push_back(mkVec(0, 1, IA, 32'h200, 0, 0, 1, NOP, 32'h10C, 0, 0, 0));
        tbl.push_back(mkVec(0, 1, IB, 32'h204, 0, 0, 1, NOP, 32'h10C, 0, 0, 0));
        tbl.push_back(mkVec(0, 1, IC, 32'h208, 0, 0, 0, NOP, 32'h10C, 0, 0, 0));
        tbl.push_back(mkVec(0, 1, IC, 32'h208, 1, 0, 0, IA,  32'h200, 0, 0, 0));
        tbl.push_back(mkVec(0, 1, IC, 32'h208, 1, 0, 1, IB,  32'h204, 0, 0, 0));
        tbl.push_back(mkVec(0, 0, 0,  0,      1, 0,  1, IC,  32'h208, 0, 1, 0));
        tbl.push_back(mkVec(0, 0, 0,  0,      1, 0,  1, NOP, 32'h208, 0, 1, 0));
        // flush with two buffered entries
        tbl.push_back(mkVec(0, 1, ID, 32'h300, 0, 0, 1, NOP, 32'h208, 0, 1, 0));
        tbl.push_back(mkVec(0, 1, IA, 32'h304, 0, 0, 1, NOP, 32'h208, 0, 0, 0));
        tbl.push_back(mkVec(0, 0, 0,  0,      1, 1,  0, NOP, 32'h208, 1, 0, 0));
        tbl.push_back(mkVec(0, 1, IB, 32'h400, 1, 0, 0, NOP, 32'h208, 0, 0, 0));
        tbl.push_back(mkVec(0, 1, IB, 32'h400, 1, 0, 0, NOP, 32'h208, 0, 0, 0));
        tbl.push_back(mkVec(0, 1, IB, 32'h400, 1, 0, 1, NOP, 32'h208, 0, 0, 0));
        tbl.push_back(mkVec(0, 0, 0,  0,      1, 0,  1, IB,  32'h400, 0, 0, 0));
        tbl.push_back(mkVec(0, 0, 0,  0,      1, 0,  1, NOP, 32'h400, 0, 0, 0));
        tbl.push_back(mkVec(0, 0, 0,  0,      1, 0,  1, NOP, 32'h400, 0, 1, 0));
        // back-to-back flushes restart the flush window
        tbl.push_back(mkVec(0, 0, 0,  0,      1, 1,  1, NOP, 32'h400, 1, 0, 0));
        tbl.push_back(mkVec(0, 0, 0,  0,      1, 1,  0, NOP, 32'h400, 1, 0, 0));
        tbl.push_back(mkVec(0, 0, 0,  0,      1, 0,  0, NOP, 32'h400, 0, 0, 0));
        tbl.push_back(mkVec(0, 0, 0,  0,      1, 0,  0, NOP, 32'h400, 0, 0, 0));
        tbl.push_back(mkVec(0, 0, 0,  0,      1, 0,  1, NOP, 32'h400, 0, 0, 0));

        foreach (tbl[i]) begin
            runVector(tbl[i], $sformatf("row%0d", i));
        end

        // lw x5 followed by a dependent add
        runVector(mkVec(0, 1, LW5,  32'h500, 1, 0, 1, NOP, 32'h400, 0, 0, 0), "hz1");
        runVector(mkVec(0, 1, ADD5, 32'h504, 1, 0, 1, LW5, 32'h500, 0, 0, 0), "hz2");
        runVector(mkVec(0, 0, 0, 0, 1, 0, 1, cStallEn ? NOP : ADD5, cStallEn ? 32'h500 : 32'h504,
                        0, 0, cStallEn ? 16'd1 : 16'd0), "hz3");
        runVector(mkVec(0, 0, 0, 0, 1, 0, 1, cStallEn ? ADD5 : NOP, 32'h504,
                        0, 1, cStallEn ? 16'd1 : 16'd0), "hz4");
        runVector(mkVec(0, 0, 0, 0, 1, 0, 1, NOP, 32'h504, 0, !cStallEn, cStallEn ? 16'd1 : 16'd0), "hz5");
        runVector(mkVec(0, 0, 0, 0, 1, 0, 1, NOP, 32'h504, 0, cStallEn, cStallEn ? 16'd1 : 16'd0), "hz6");

        // loads into x0 never create a hazard
        runVector(mkVec(0, 1, LW0,  32'h600, 1, 0, 1, NOP,  32'h504, 0, 0, cStallEn ? 16'd1 : 16'd0), "x0a");
        runVector(mkVec(0, 1, ADD0, 32'h604, 1, 0, 1, LW0,  32'h600, 0, 0, cStallEn ? 16'd1 : 16'd0), "x0b");
        runVector(mkVec(0, 0, 0, 0, 1, 0,            1, ADD0, 32'h604, 0, 0, cStallEn ? 16'd1 : 16'd0), "x0c");
        runVector(mkVec(0, 0, 0, 0, 1, 0,            1, NOP,  32'h604, 0, 1, cStallEn ? 16'd1 : 16'd0), "x0d");
        runVector(mkVec(0, 0, 0, 0, 1, 0,            1, NOP,  32'h604, 0, 1, cStallEn ? 16'd1 : 16'd0), "x0e");

        // reset arriving in the stall cycle drops the held instruction
        runVector(mkVec(0, 1, LW5,  32'h700, 1, 0, 1, NOP, 32'h604, 0, 0, cStallEn ? 16'd1 : 16'd0), "rs1");
        runVector(mkVec(0, 1, ADD5, 32'h704, 1, 0, 1, LW5, 32'h700, 0, 0, cStallEn ? 16'd1 : 16'd0), "rs2");
        runVector(mkVec(0, 0, 0, 0, 1, 0, 1, cStallEn ? NOP : ADD5, cStallEn ? 32'h700 : 32'h704,
                        0, 0, cStallEn ? 16'd2 : 16'd0), "rs3");
        runVector(mkVec(1, 0, 0, 0, 1, 0, 0, NOP, 32'h000, 0, 0, 0), "rs4");
        runVector(mkVec(0, 0, 0, 0, 1, 0, 1, NOP, 32'h000, 0, 0, 0), "rs5");
        runVector(mkVec(0, 0, 0, 0, 1, 0, 1, NOP, 32'h000, 0, 0, 0), "rs6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_issue_ctrl.md
DECODE_ISSUE_CTRL -- requirements
Module: decode_issue_ctrl

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high: iClk and iRst.
REQ-002 SHALL have parameter cXLEN, default 32: instruction and PC width.
REQ-003 SHALL have parameter cycleNum, default 2: decoder pipeline latency in cycles.
REQ-004 SHALL have port iClk, input, 1: clock.
REQ-005 SHALL have port iRst, input, 1: synchronous active-high reset.
REQ-006 SHALL have port iFetchValid, input, 1: fetch presents an instruction.
REQ-007 SHALL have port iFetchInst, input, cXLEN: fetched instruction.
REQ-008 SHALL have port iFetchPC, input, cXLEN: PC of the fetched instruction.
REQ-009 SHALL have port oFetchReady, output, 1: controller accepts the fetch word this cycle.
REQ-010 SHALL have port iExReady, input, 1: execute can take a new instruction.
REQ-011 SHALL have port iFlushPipe, input, 1: redirect or mispredict flush request.
REQ-012 SHALL have port oInst, output, cXLEN: instruction driven to decoder iInst.
REQ-013 SHALL have port oCurPC, output, cXLEN: PC driven to decoder iCurPC.
REQ-014 SHALL have port oFlushPipe, output, 1: flush driven to decoder iFlushPipe.
REQ-015 SHALL have port oDecValid, output, 1: decoder output valid, aligned with decoder outputs.
REQ-016 SHALL have port oBubbleCnt, output, 16: count of inserted load-use bubbles.

Function
REQ-017 SHALL buffer accepted fetch words ({inst,PC}) in a 2-entry FIFO; accept when iFetchValid && oFetchReady.
REQ-018 SHALL drive oFetchReady = (FIFO count < 2) && state != FLUSH, decoded from registers only.
REQ-019 SHALL implement states RUN, STALL, FLUSH.
REQ-020 SHALL issue in RUN when the FIFO is non-empty, iExReady=1 and no hazard: the head is popped and registered onto oInst/oCurPC next cycle with issue-valid=1.
REQ-021 SHALL register NOP 0x00000013 onto oInst, with oCurPC held and issue-valid=0, in any cycle without an issue.
REQ-022 SHALL shift issue-valid through a cycleNum-deep register; oDecValid SHALL be its last stage.
REQ-023 SHALL detect a hazard when the last issued instruction has opcode 0000011 with rd!=0, and the head's rs1 equals that rd, or the head's rs2 equals it for opcodes 0110011, 0100011 or 1100011.
REQ-024 SHALL, on a hazard in RUN, issue one NOP, enter STALL for one cycle, increment oBubbleCnt, then return to RUN and issue the held head.
REQ-025 SHALL saturate oBubbleCnt at 0xFFFF.
REQ-026 SHALL, when iFlushPipe=1 in any state, take priority over accept, issue and hazard in that cycle.
REQ-027 A flush SHALL empty the FIFO, clear the valid shift register and the last-issued record, register oFlushPipe=1 for exactly one cycle, and enter FLUSH.
REQ-028 SHALL remain in FLUSH for cycleNum cycles with oFetchReady=0, then return to RUN.
REQ-029 A flush arriving while in FLUSH SHALL restart the cycleNum count.
REQ-030 With iExReady=0, the head SHALL be held, NOPs issued, and accepts continue until the FIFO is full.
REQ-031 Simultaneous accept and pop SHALL leave the count unchanged; the FIFO pointers SHALL wrap modulo 2.

Reset
REQ-032 On iRst=1 at a rising edge, the state SHALL go to RUN and the FIFO SHALL empty.
REQ-033 On reset, oInst SHALL be 0x00000013, oCurPC 0, oFlushPipe 0, oDecValid 0 with the valid shift register 0, and oBubbleCnt 0.
REQ-034 While iRst=1, oFetchReady SHALL be 0.
REQ-035 A reset asserted mid-STALL or mid-FLUSH SHALL abandon the operation without any oFlushPipe pulse.

Configuration
REQ-036 With macro LOAD_USE_STALL_EN defined, REQ-023 to REQ-025 SHALL apply.
REQ-037 Without LOAD_USE_STALL_EN, no hazard SHALL be detected, STALL SHALL be unreachable and oBubbleCnt SHALL be tied to 0.

Verification
REQ-038 Fetch 4 ALU instructions back-to-back with iExReady=1 -> each appears on oInst one cycle after accept; oDecValid=1 cycleNum cycles later, 4 consecutive cycles.
REQ-039 Issue lw x5,0(x1) then add x6,x5,x2 -> one NOP between them, oBubbleCnt=1; without LOAD_USE_STALL_EN, no NOP and count 0.
REQ-040 Issue lw x0,0(x1) then add x6,x0,x2 -> no bubble.
REQ-041 Fill the FIFO with iExReady=0 -> oFetchReady=0 after 2 accepts; raise iExReady -> both issue in order and ready returns.
REQ-042 Assert iFlushPipe with 2 buffered entries -> oFlushPipe pulses one cycle, oDecValid=0 for the following cycleNum+1 cycles, the buffered entries are never issued, and oFetchReady=0 for cycleNum cycles.
REQ-043 Assert iRst during STALL -> next cycle oInst=0x00000013, oBubbleCnt=0, FIFO empty.
